// File: rtl/burst_pkg.sv
// burst_pkg: shared state type and address helpers for burst_splitter
package burst_pkg;
    typedef enum logic [1:0] {IDLE, RBURST, WBURST} state_e;
    function automatic int unsigned bytes_of(input int unsigned dw);
        return dw / 8;
    endfunction
    function automatic logic is_pow2(input logic [31:0] v);
        return (v != '0) && ((v & (v - 32'd1)) == '0);
    endfunction
    function automatic logic [31:0] wrap_mask(input logic [31:0] len, input int unsigned bytes);
        return len * bytes - 32'd1;
    endfunction
endpackage

// File: rtl/burst_splitter_if.sv
// burst_splitter_if: upstream bursting master and downstream single-beat slave signals
interface burst_splitter_if #(
    parameter int IADDR = 32,
    parameter int OADDR = 32,
    parameter int DW    = 32,
    parameter int BCW   = 4,
    parameter int PW    = 5
);
    logic [IADDR-1:0] addr_in;
    logic             write_in;
    logic [DW-1:0]    writedata_in;
    logic [DW/8-1:0]  byteenable_in;
    logic             read_in;
    logic [BCW-1:0]   burstcount_in;
    logic             waitrequest_out;
    logic [DW-1:0]    readdata_out;
    logic             readdatavalid_out;
    logic [OADDR-1:0] addr_out;
    logic             write_out;
    logic             read_out;
    logic [DW-1:0]    writedata_out;
    logic [DW/8-1:0]  byteenable_out;
    logic [DW-1:0]    readdata_in;
    logic             readdatavalid_in;
    logic             waitrequest_in;
    logic [PW-1:0]    rd_pend_out;
    modport slave (
        input  addr_in, write_in, writedata_in, byteenable_in, read_in, burstcount_in,
        input  readdata_in, readdatavalid_in, waitrequest_in,
        output waitrequest_out, readdata_out, readdatavalid_out, addr_out, write_out, read_out,
        output writedata_out, byteenable_out, rd_pend_out
    );
    modport master (
        output addr_in, write_in, writedata_in, byteenable_in, read_in, burstcount_in,
        output readdata_in, readdatavalid_in, waitrequest_in,
        input  waitrequest_out, readdata_out, readdatavalid_out, addr_out, write_out, read_out,
        input  writedata_out, byteenable_out, rd_pend_out
    );
endinterface

// File: rtl/burst_addr_gen.sv
// burst_addr_gen: beat address from burst base, beat index and burst length (linear or wrapping)
module burst_addr_gen
    import burst_pkg::*;
#(
    parameter int IADDR = 32,
    parameter int DW    = 32,
    parameter int BCW   = 4,
    parameter int WRAP  = 0
) (
    input  logic [IADDR-1:0] base,
    input  logic [BCW-1:0]   idx,
    input  logic [BCW-1:0]   len,
    output logic [IADDR-1:0] addr
);
    localparam int unsigned BYTES = bytes_of(DW);
    logic [IADDR-1:0] lin, mask;
    always_comb begin
        lin = base + IADDR'(idx) * IADDR'(BYTES);
        mask = IADDR'(wrap_mask(32'(len), BYTES));
        addr = (WRAP != 0 && is_pow2(32'(len))) ? ((base & ~mask) | (lin & mask)) : lin;
    end
endmodule

// File: rtl/burst_splitter.sv
// burst_splitter: Avalon-MM burst to single-beat converter with wrap support and read-pending limit
module burst_splitter
    import burst_pkg::*;
#(
    parameter int IADDR    = 32,
    parameter int OADDR    = 32,
    parameter int DW       = 32,
    parameter int BCW      = 4,
    parameter int WRAP     = 0,
    parameter int MAX_PEND = 16
) (
    input logic             clk_sys,
    input logic             rst,
    burst_splitter_if.slave bus
);
    localparam int PW = $clog2(MAX_PEND + 1);
    state_e state_q, state_d;
    logic [IADDR-1:0] base_q, base_d, beat_addr;
    logic [BCW-1:0] idx_q, idx_d, rem_q, rem_d, len_q, len_d, cnt;
    logic [PW-1:0] pend_q, pend_d;
    logic pend_full, rd_acc, wr_acc;
    burst_addr_gen #(.IADDR(IADDR), .DW(DW), .BCW(BCW), .WRAP(WRAP)) u_addr (
        .base(base_q),
        .idx (idx_q),
        .len (len_q),
        .addr(beat_addr)
    );
    always_comb begin
        cnt = (bus.burstcount_in == '0) ? BCW'(1) : bus.burstcount_in;
        pend_full = pend_q == PW'(MAX_PEND);
        bus.addr_out = OADDR'(state_q == IDLE ? bus.addr_in : beat_addr);
        bus.read_out = !rst && (state_q == IDLE ? bus.read_in && !pend_full : state_q == RBURST && !pend_full);
        bus.write_out = !rst && (state_q == IDLE ? bus.write_in && !bus.read_in : state_q == WBURST && bus.write_in);
        bus.waitrequest_out = rst || (state_q == IDLE ? bus.waitrequest_in || (bus.read_in && pend_full)
                                                      : state_q == RBURST || bus.waitrequest_in);
        bus.writedata_out = bus.writedata_in;
        bus.byteenable_out = bus.byteenable_in;
        bus.readdata_out = bus.readdata_in;
        bus.readdatavalid_out = bus.readdatavalid_in;
        bus.rd_pend_out = pend_q;
        rd_acc = bus.read_out && !bus.waitrequest_in;
        wr_acc = bus.write_out && !bus.waitrequest_in;
        state_d = state_q;
        base_d = base_q;
        idx_d = idx_q;
        rem_d = rem_q;
        len_d = len_q;
        if (state_q == IDLE && (rd_acc || wr_acc) && cnt > BCW'(1)) begin
            state_d = rd_acc ? RBURST : WBURST;
            base_d = bus.addr_in;
            len_d = cnt;
            idx_d = BCW'(1);
            rem_d = cnt - BCW'(1);
        end else if (state_q != IDLE && (rd_acc || wr_acc)) begin
            idx_d = idx_q + BCW'(1);
            rem_d = rem_q - BCW'(1);
            state_d = (rem_q == BCW'(1)) ? IDLE : state_q;
        end
        // a valid with no outstanding beat is a stray response and must not underflow
        pend_d = (rd_acc && bus.readdatavalid_in) ? pend_q
               : rd_acc ? pend_q + PW'(1)
               : (bus.readdatavalid_in && pend_q != '0) ? pend_q - PW'(1) : pend_q;
    end
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q <= IDLE;
            base_q <= '0;
            idx_q <= '0;
            rem_q <= '0;
            len_q <= '0;
            pend_q <= '0;
        end else begin
            state_q <= state_d;
            base_q <= base_d;
            idx_q <= idx_d;
            rem_q <= rem_d;
            len_q <= len_d;
            pend_q <= pend_d;
        end
    end
endmodule

// File: tb/tb_burst_splitter.sv
// tb_burst_splitter: directed stimulus with a per-cycle reference model and literal beat checks
module tb_burst_splitter;
    localparam int IADDR = 32, OADDR = 32, DW = 32, BCW = 4, WRAP = 1, MAX_PEND = 2;
    localparam int PW = $clog2(MAX_PEND + 1);
    logic clk_sys = 1'b0;
    logic rst = 1'b1;
    int checks = 0, errors = 0;
    int cyc = 0, lat = 1, max_pend = 0;
    int m_left = 0, m_idx = 0, m_len = 0, m_pend = 0;
    bit m_rd = 1'b0;
    logic [31:0] m_base = '0;
    logic [31:0] la[$], ld[$], rq_dat[$];
    logic [3:0] lb[$];
    bit lw[$];
    int lc[$], rq_due[$];
    burst_splitter_if #(.IADDR(IADDR), .OADDR(OADDR), .DW(DW), .BCW(BCW), .PW(PW)) bus ();
    burst_splitter #(.IADDR(IADDR), .OADDR(OADDR), .DW(DW), .BCW(BCW), .WRAP(WRAP), .MAX_PEND(MAX_PEND)) dut (
        .clk_sys(clk_sys),
        .rst    (rst),
        .bus    (bus)
    );
    always #5 clk_sys = ~clk_sys;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask
    // expected beat address straight from the burst rules: window start plus offset modulo window size
    function automatic logic [31:0] model_addr(input logic [31:0] base, input int len, input int idx);
        logic [31:0] span, off;
        span = 32'(len) * 32'(DW / 8);
        off = 32'(idx) * 32'(DW / 8);
        if (WRAP != 0 && (span & (span - 32'd1)) == 32'd0)
            return (base - base % span) + (base % span + off) % span;
        return base + off;
    endfunction
    always @(negedge clk_sys) begin : model
        bit full, er, ew, ewait, acc;
        logic [31:0] ea;
        int n;
        full = m_pend == MAX_PEND;
        ea = (m_left == 0) ? bus.addr_in : model_addr(m_base, m_len, m_idx);
        if (rst) begin
            er = 1'b0;
            ew = 1'b0;
            ewait = 1'b1;
        end else if (m_left == 0) begin
            er = bus.read_in && !full;
            ew = bus.write_in && !bus.read_in;
            ewait = bus.waitrequest_in || (bus.read_in && full);
        end else begin
            er = m_rd && !full;
            ew = !m_rd && bus.write_in;
            ewait = m_rd || bus.waitrequest_in;
        end
        chk("read_out", 64'(bus.read_out), 64'(er));
        chk("write_out", 64'(bus.write_out), 64'(ew));
        chk("waitrequest_out", 64'(bus.waitrequest_out), 64'(ewait));
        chk("rd_pend_out", 64'(bus.rd_pend_out), 64'(m_pend));
        chk("writedata_out", 64'(bus.writedata_out), 64'(bus.writedata_in));
        chk("byteenable_out", 64'(bus.byteenable_out), 64'(bus.byteenable_in));
        chk("readdata_out", 64'(bus.readdata_out), 64'(bus.readdata_in));
        chk("readdatavalid_out", 64'(bus.readdatavalid_out), 64'(bus.readdatavalid_in));
        if (er || ew) chk("addr_out", 64'(bus.addr_out), 64'(ea));
        if (!rst && (bus.read_out || bus.write_out) && !bus.waitrequest_in) begin
            la.push_back(bus.addr_out);
            ld.push_back(bus.writedata_out);
            lb.push_back(bus.byteenable_out);
            lw.push_back(bus.write_out);
            lc.push_back(cyc);
            if (bus.read_out) begin
                rq_due.push_back(cyc + lat);
                rq_dat.push_back(32'hC0DE_0000 ^ bus.addr_out);
            end
        end
        if (int'(bus.rd_pend_out) > max_pend) max_pend = int'(bus.rd_pend_out);
        if (rst) begin
            m_left = 0;
            m_pend = 0;
        end else begin
            acc = (er || ew) && !bus.waitrequest_in;
            if (er && !bus.waitrequest_in) begin
                if (!bus.readdatavalid_in) m_pend++;
            end else if (bus.readdatavalid_in && m_pend > 0) m_pend--;
            if (acc && m_left == 0) begin
                n = (bus.burstcount_in == '0) ? 1 : int'(bus.burstcount_in);
                if (n > 1) begin
                    m_rd = er;
                    m_base = bus.addr_in;
                    m_len = n;
                    m_idx = 1;
                    m_left = n - 1;
                end
            end else if (acc) begin
                m_idx++;
                m_left--;
            end
        end
    end
    initial begin
        bus.readdatavalid_in = 1'b0;
        bus.readdata_in = '0;
        forever begin
            @(posedge clk_sys);
            cyc++;
            #1;
            if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
                bus.readdatavalid_in = 1'b1;
                bus.readdata_in = rq_dat.pop_front();
                void'(rq_due.pop_front());
            end else begin
                bus.readdatavalid_in = 1'b0;
                bus.readdata_in = 32'h0BAD_0000 | 32'(cyc);
            end
        end
    end
    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask
    task automatic clr();
        la.delete(); ld.delete(); lb.delete(); lw.delete(); lc.delete();
    endtask
    task automatic issue(input bit rd, input bit wr, input logic [31:0] a, input logic [3:0] bc,
                         input logic [31:0] d, input logic [3:0] be, input int stall);
        bit accepted;
        bus.read_in = rd;
        bus.write_in = wr;
        bus.addr_in = a;
        bus.burstcount_in = bc;
        bus.writedata_in = d;
        bus.byteenable_in = be;
        bus.waitrequest_in = stall > 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_sys);
            accepted = !bus.waitrequest_out;
            tick();
            if (i + 1 >= stall) bus.waitrequest_in = 1'b0;
            if (accepted) begin
                bus.read_in = 1'b0;
                bus.write_in = 1'b0;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL issue_timeout: got no accept expected accept within 50 cycles");
        bus.read_in = 1'b0;
        bus.write_in = 1'b0;
        bus.waitrequest_in = 1'b0;
    endtask
    task automatic wait_beats(input int n);
        for (int i = 0; i < 100 && la.size() < n; i++) @(posedge clk_sys);
        #1;
        checks++;
        if (la.size() < n) begin
            errors++;
            $display("FAIL wait_beats: got %0d beats expected %0d", la.size(), n);
        end
    endtask
    task automatic chk_beat(input string name, input int i, input logic [31:0] a, input bit w, input int off);
        if (la.size() <= i) begin
            checks++;
            errors++;
            $display("FAIL %s: got %0d beats expected more than %0d", name, la.size(), i);
            return;
        end
        chk(name, 64'(la[i]), 64'(a));
        chk({name, "_kind"}, 64'(lw[i]), 64'(w));
        if (off >= 0) chk({name, "_cycle"}, 64'(lc[i] - lc[0]), 64'(off));
    endtask
    initial begin
        int nval;
        bus.read_in = 1'b0;
        bus.write_in = 1'b0;
        bus.waitrequest_in = 1'b0;
        bus.addr_in = '0;
        bus.burstcount_in = '0;
        bus.writedata_in = '0;
        bus.byteenable_in = '0;
        tick();
        tick();
        @(negedge clk_sys);
        chk("rst_waitrequest", 64'(bus.waitrequest_out), 64'(1));
        chk("rst_read", 64'(bus.read_out), 64'(0));
        tick();
        rst = 1'b0;
        @(negedge clk_sys);
        chk("reset_pend", 64'(bus.rd_pend_out), 64'(0));
        chk("reset_idle_wait", 64'(bus.waitrequest_out), 64'(0));
        tick();
        clr();
        lat = 1;
        issue(1, 0, 32'h100, 4'd4, '0, '0, 0);
        @(negedge clk_sys);
        chk("t1_wait_c2", 64'(bus.waitrequest_out), 64'(1));
        wait_beats(4);
        @(negedge clk_sys);
        chk("t1_wait_c5", 64'(bus.waitrequest_out), 64'(0));
        chk_beat("t1_b0", 0, 32'h100, 0, 0);
        chk_beat("t1_b1", 1, 32'h104, 0, 1);
        chk_beat("t1_b2", 2, 32'h108, 0, 2);
        chk_beat("t1_b3", 3, 32'h10C, 0, 3);
        repeat (3) tick();
        clr();
        issue(0, 1, 32'h200, 4'd3, 32'h1111_AAAA, 4'hF, 0);
        tick();
        tick();
        issue(0, 1, 32'hDEAD_BEE0, 4'd7, 32'h2222_BBBB, 4'h3, 0);
        issue(0, 1, 32'h0000_0F00, 4'd0, 32'h3333_CCCC, 4'hC, 1);
        tick();
        chk("t2_count", 64'(la.size()), 64'(3));
        chk_beat("t2_b0", 0, 32'h200, 1, 0);
        chk_beat("t2_b1", 1, 32'h204, 1, 3);
        chk_beat("t2_b2", 2, 32'h208, 1, 5);
        if (la.size() == 3) begin
            chk("t2_d0", 64'(ld[0]), 64'(32'h1111_AAAA));
            chk("t2_d1", 64'(ld[1]), 64'(32'h2222_BBBB));
            chk("t2_d2", 64'(ld[2]), 64'(32'h3333_CCCC));
            chk("t2_be0", 64'(lb[0]), 64'(4'hF));
            chk("t2_be1", 64'(lb[1]), 64'(4'h3));
            chk("t2_be2", 64'(lb[2]), 64'(4'hC));
        end
        clr();
        issue(1, 0, 32'h108, 4'd4, '0, '0, 0);
        wait_beats(4);
        chk_beat("t3w_b0", 0, 32'h108, 0, 0);
        chk_beat("t3w_b1", 1, 32'h10C, 0, 1);
        chk_beat("t3w_b2", 2, 32'h100, 0, 2);
        chk_beat("t3w_b3", 3, 32'h104, 0, 3);
        repeat (3) tick();
        clr();
        issue(1, 0, 32'h108, 4'd3, '0, '0, 0);
        wait_beats(3);
        chk_beat("t3l_b0", 0, 32'h108, 0, 0);
        chk_beat("t3l_b1", 1, 32'h10C, 0, 1);
        chk_beat("t3l_b2", 2, 32'h110, 0, 2);
        repeat (3) tick();
        clr();
        lat = 5;
        max_pend = 0;
        issue(1, 0, 32'h300, 4'd4, '0, '0, 0);
        wait_beats(4);
        chk_beat("t4_b0", 0, 32'h300, 0, 0);
        chk_beat("t4_b1", 1, 32'h304, 0, 1);
        chk_beat("t4_b2", 2, 32'h308, 0, 6);
        chk_beat("t4_b3", 3, 32'h30C, 0, 7);
        repeat (8) tick();
        chk("t4_max_pend", 64'(max_pend), 64'(2));
        chk("t4_drained", 64'(bus.rd_pend_out), 64'(0));
        clr();
        lat = 4;
        issue(1, 0, 32'h400, 4'd4, '0, '0, 0);
        wait_beats(2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk_sys);
        chk("t5_pend_after_rst", 64'(bus.rd_pend_out), 64'(0));
        chk("t5_idle_wait", 64'(bus.waitrequest_out), 64'(0));
        chk("t5_no_read", 64'(bus.read_out), 64'(0));
        nval = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            @(negedge clk_sys);
            nval += int'(bus.readdatavalid_out);
            chk("t5_pend_zero", 64'(bus.rd_pend_out), 64'(0));
        end
        chk("t5_late_valids", 64'(nval), 64'(2));
        chk("t5_beats", 64'(la.size()), 64'(2));
        tick();
        lat = 1;
        for (int k = 0; k < 5; k++) begin
            logic [31:0] a;
            bit rd, wr;
            a = 32'h500 + 32'(k * 16);
            rd = (k == 0 || k == 1 || k == 4);
            wr = (k >= 2);
            clr();
            issue(rd, wr, a, (k == 1 || k >= 3) ? 4'd1 : 4'd0, 32'h5555_0000 | 32'(k), 4'hF, 0);
            @(negedge clk_sys);
            chk("t6_no_burst_wait", 64'(bus.waitrequest_out), 64'(0));
            tick();
            tick();
            chk("t6_count", 64'(la.size()), 64'(1));
            chk_beat("t6_beat", 0, a, k == 2 || k == 3, -1);
        end
        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1);
    end
endmodule

// File: doc/burst_splitter.md
# burst_splitter

Parametrised Avalon-MM burst-to-single-beat converter that sits between a bursting master (CPU/DMA side) and a non-bursting slave (memory or peripheral bridge). It generalises the fixed 32-bit, max-4-beat converter: configurable data width, max burst length, wrapping bursts, a true write-burst sequencer with per-beat data handshake, and a bounded outstanding-read counter. Read data is forwarded unchanged.

## Interface
- IADDR, 32, upstream byte-address width
- OADDR, 32, downstream address width; addr_out = low OADDR bits of computed beat address
- DW, 32, data width; multiple of 8, power of two; BYTES = DW/8
- BCW, 4, burstcount width; max burst = 2^(BCW-1)
- WRAP, 0, 1 = wrapping bursts for power-of-two counts, 0 = linear only
- MAX_PEND, 16, max outstanding read beats downstream (>=1)
- clk_sys  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- addr_in  in  IADDR  burst start byte address (sampled on first beat only)
- write_in  in  1  write beat request
- writedata_in  in  DW  write data
- byteenable_in  in  DW/8  byte enables, per beat
- read_in  in  1  read burst request
- burstcount_in  in  BCW  beats in burst; 0 treated as 1
- waitrequest_out  out  1  stall to upstream
- readdata_out  out  DW  = readdata_in
- readdatavalid_out  out  1  = readdatavalid_in
- addr_out  out  OADDR  beat address
- write_out / read_out  out  1  single-beat commands
- writedata_out  out  DW  = writedata_in
- byteenable_out  out  DW/8  = byteenable_in
- readdata_in  in  DW, readdatavalid_in  in  1, waitrequest_in  in  1  slave side
- rd_pend_out  out  $clog2(MAX_PEND+1)  outstanding read beats (debug)

## Operation
- States: IDLE, RBURST, WBURST. Registers: base, idx (beat index), rem (beats left), len (latched count), pend.
- IDLE: addr_out = addr_in; write_out = write_in; read_out = read_in && !pend_full; waitrequest_out = waitrequest_in || (read_in && pend_full). Read and write both high in IDLE: read wins, write_out = 0.
- First beat accepted (cmd && !waitrequest_in) with count > 1: latch base = addr_in, len = count, idx = 1, rem = count-1; go RBURST or WBURST. Count <= 1: stay IDLE.
- RBURST: read_out = !pend_full; waitrequest_out = 1; addr_out = beat address(idx). Each accepted beat: idx++, rem--; rem reaching 0 -> IDLE.
- WBURST: write_out = write_in; waitrequest_out = waitrequest_in; addr/burstcount inputs ignored; advance on write_in && !waitrequest_in; last beat -> IDLE. read_in ignored (read_out = 0).
- Beat address: linear = base + idx*BYTES mod 2^IADDR. WRAP=1 and len power of two: mask = len*BYTES-1, addr = (base & ~mask) | ((base + idx*BYTES) & mask); otherwise linear.
- pend: +1 per accepted read beat, -1 per readdatavalid_in; both same cycle -> unchanged; never below 0 (stray valids after reset ignored); pend_full = (pend == MAX_PEND).
- Reset: state IDLE, idx/rem/len/base/pend = 0. While rst high: read_out = write_out = 0, waitrequest_out = 1. All other outputs combinational pass-through. Reset mid-burst abandons remaining beats.

## Timing
- First beat: zero-cycle combinational path upstream -> downstream.
- N-beat read: N downstream beats in N cycles minimum; waitrequest_out high from cycle after first-beat accept through cycle of last-beat accept.
- Write beats paced by upstream write_in and downstream waitrequest_in; one beat per cycle max.
- Read responses: zero latency pass-through, order preserved.
- pend updates on the clock edge after the event; rd_pend_out registered.

## Structure
- Package burst_pkg: state enum (IDLE/RBURST/WBURST), function for BYTES and wrap mask, ispow2 helper.
- Sub-module burst_addr_gen: combinational (base, idx, len, WRAP) -> beat address.

## Test plan
- Read, addr 0x100, count 4, DW=32, no stall -> addr_out 0x100,0x104,0x108,0x10C on 4 consecutive cycles; waitrequest_out high cycles 2-4.
- Write, count 3, write_in gap of 2 cycles before beat 2, waitrequest_in high 1 cycle on beat 3 -> 3 writes at 0x200,0x204,0x208 with correct data/byteenable.
- WRAP=1, read addr 0x108, count 4 -> 0x108,0x10C,0x100,0x104; count 3 -> linear 0x108,0x10C,0x110.
- MAX_PEND=2, slave delays readdatavalid 5 cycles, read count 4 -> read_out drops after 2 beats, resumes on each valid; rd_pend_out never exceeds 2.
- rst asserted after 2nd beat of 4-beat read -> next cycle IDLE, rd_pend_out 0, late readdatavalid passes through with rd_pend_out staying 0.
- Burstcount 0 and 1 read/write -> single downstream beat, no burst state entered.
